bsearch_gen: RTL
================

// Module: bsearch_gen
// PURPOSE
// - Parametrised binary-search engine over an external, ascending-sorted, single-read-port memory of 2**ADDR_W words.
// - Supports three search modes:
//   - exact match, returning the lowest matching index when there are duplicates;
//   - lower bound (first element >= key);
//   - upper bound (first element > key).
// - Has a configurable memory read latency, so one engine serves both on-chip block RAM and registered-output RAM.
// - Sits between a control FSM or test harness (start/done handshake) and the lookup RAM.
// PARAMETERS
// - DATA_W  8  width of the key and of each memory word (unsigned compare)
// - ADDR_W  5  address width; DEPTH = 2**ADDR_W words
// - RD_LAT  1  cycles from mem_rd_en/mem_addr to valid mem_rdata; must be >= 1
// PORTS
// - clk        in   1       single clock; all state updates on the rising edge
// - reset      in   1       synchronous, active-high
// - start      in   1       level request; sampled only in IDLE
// - A          in   DATA_W  search key; latched when start is accepted
// - mode       in   2       00 exact, 01 lower bound, 10 upper bound, 11 treated as exact; latched with A
// - mem_addr   out  ADDR_W  probe address
// - mem_rd_en  out  1       one-cycle read strobe per probe
// - mem_rdata  in   DATA_W  read data, valid RD_LAT cycles after mem_rd_en
// - busy       out  1       high from start acceptance until DONE is entered
// - done       out  1       high while in DONE
// - found      out  1       result index valid (qualified by done)
// - notfound   out  1       no valid index (qualified by done)
// - loc        out  ADDR_W  result index; 0 when notfound
// BEHAVIOUR
// - Reset: FSM goes to IDLE. busy, done, found, notfound, mem_rd_en = 0. loc and mem_addr = 0. Latched key and mode cleared.
// - Reset mid-search aborts the search the next cycle; no partial result is ever reported.
// - Search uses a half-open window [lo,hi), where lo and hi are ADDR_W+1 bits wide.
// - IDLE:
//   - If start is high: latch A and mode, set lo=0, hi=DEPTH, set hit=0, assert busy, go to ISSUE.
// - ISSUE (1 cycle):
//   - mid = (lo+hi)>>1, computed at ADDR_W+1 bits with no overflow.
//   - Drive mem_addr = mid and assert mem_rd_en; go to WAIT.
// - WAIT (RD_LAT cycles, down-counter):
//   - In the last WAIT cycle mem_rdata is valid and is compared.
//   - Exact/lower mode: if rdata < key then lo = mid+1, else hi = mid.
//   - Upper mode: if rdata <= key then lo = mid+1, else hi = mid.
//   - When hi is updated, set hit = (rdata == key).
//   - If the new lo == new hi, go to DONE; otherwise go to ISSUE.
// - Probe count:
//   - Each probe costs RD_LAT+1 cycles.
//   - At most ADDR_W+1 probes, at least ADDR_W.
//   - done rises no later than 1 + (ADDR_W+1)*(RD_LAT+1) cycles after the edge on which start is accepted.
// - DONE:
//   - Result is registered on entry.
//   - Exact mode: found = hit.
//   - Lower/upper mode: found = (lo < DEPTH).
//   - notfound = ~found. loc = lo[ADDR_W-1:0] if found, else 0.
//   - A key past the top of the array reports notfound, never a wrapped index.
//   - Stay in DONE while start is high. Go to IDLE on the first cycle start is low, so done lasts 1 cycle if start is already low.
// - Outside DONE, done, found and notfound are 0. loc holds its last value until the next start is accepted.
// - Changes on A, mode or start during a search are ignored.
// - start held high through DONE does not retrigger; it must drop low for at least one cycle.
// - mem_rd_en is never asserted outside ISSUE. mem_addr holds its value between probes.
// STRUCTURE
// - Package bsearch_pkg holds:
//   - mode enum (BS_EXACT, BS_LOWER, BS_UPPER);
//   - FSM state enum (IDLE, ISSUE, WAIT, DONE).
// - One sub-module, bsearch_gen_datapath, holds the lo/hi/mid registers, the compare, the hit flag, the latency counter and the result registers.
// - The top level holds the FSM and connects status and control between the FSM and the datapath.
// TESTING
// - Bench memory model has DEPTH=32, RD_LAT=1, contents mem[i]=2*i unless noted.
// 1. Exact, A=20 -> found=1, loc=10, mem_rd_en pulse count <= 6, done within 13 cycles of start.
// 2. Exact, A=21 -> notfound=1, found=0, loc=0. Release start -> done drops the next cycle.
// 3. Lower, A=21 -> found, loc=11. Upper, A=20 -> found, loc=11. Lower, A=0 -> found, loc=0.
// 4. Lower, A=63; upper, A=62; exact, A=255 -> each notfound=1, loc=0 (no wrap to index 0 as a hit).
// 5. Duplicates mem[4..7]=9, other words ascending around them: exact A=9 -> loc=4; upper A=9 -> loc=8. Rerun test 1 with RD_LAT=2 -> same result, done within 19 cycles.
// 6. Assert reset during the 3rd probe -> next cycle busy=0, done=0, mem_rd_en=0; then start with A=40 exact -> loc=20.

Source files
------------

// File: rtl/bsearch_pkg.sv
`default_nettype none
// ============================================================================
// Module : bsearch_pkg
// Brief  : Shared types for the binary-search engine: search modes, FSM
//          states and the mode-decode helper.
// Rev    : 1.0  initial release
// ============================================================================
package bsearch_pkg;

  typedef enum logic [1:0] {
    BS_EXACT = 2'b00,
    BS_LOWER = 2'b01,
    BS_UPPER = 2'b10
  } bs_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } bs_state_e;

  // The unused encoding 2'b11 falls back to an exact search.
  function automatic bs_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   decode_mode = BS_LOWER;
      2'b10:   decode_mode = BS_UPPER;
      default: decode_mode = BS_EXACT;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsearch_gen_if.sv
`default_nettype none
// ============================================================================
// Module : bsearch_gen_if
// Brief  : Request/result handshake and lookup-RAM read port of the
//          binary-search engine. slave = engine side, master = harness/RAM.
// Rev    : 1.0  initial release
// ============================================================================
interface bsearch_gen_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [DATA_W-1:0] A;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              found;
  logic              notfound;
  logic [ADDR_W-1:0] loc;

  modport slave (
    input  start, A, mode, mem_rdata,
    output mem_addr, mem_rd_en, busy, done, found, notfound, loc
  );

  modport master (
    output start, A, mode, mem_rdata,
    input  mem_addr, mem_rd_en, busy, done, found, notfound, loc
  );
endinterface
`default_nettype wire

// File: rtl/bsearch_gen_datapath.sv
`default_nettype none
// ============================================================================
// Module : bsearch_gen_datapath
// Brief  : Search window [lo,hi), probe address, read-latency counter,
//          compare, hit flag and registered result of the search engine.
// Rev    : 1.0  initial release
// ============================================================================
module bsearch_gen_datapath
  import bsearch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              issue,
  input  logic              in_wait,
  input  logic [DATA_W-1:0] key_in,
  input  logic [1:0]        mode_in,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              converge,
  output logic              found,
  output logic [ADDR_W-1:0] loc
);

  localparam int                CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] key;
  bs_mode_e          mode;
  logic [ADDR_W:0]   lo, hi, probe;
  logic              hit;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W:0]   mid, lo_n, hi_n;
  logic              less, hit_n, res_found;

  // Next-window computation from the probe result; mid is formed as
  // lo + (hi-lo)/2 so it never needs more than ADDR_W+1 bits.
  always_comb begin
    mid       = lo + ((hi - lo) >> 1);
    less      = (mode == BS_UPPER) ? (rdata <= key) : (rdata < key);
    lo_n      = less ? (probe + 1'b1) : lo;
    hi_n      = less ? hi : probe;
    hit_n     = less ? hit : (rdata == key);
    res_found = (mode == BS_EXACT) ? hit_n : ~lo_n[ADDR_W];
    last      = (cnt == '0);
    converge  = (lo_n == hi_n);
    addr      = issue ? mid[ADDR_W-1:0] : probe[ADDR_W-1:0];
  end

  // Window, counter and result registers; the result is captured on the
  // final compare so it is stable for the whole DONE interval.
  always_ff @(posedge clk) begin
    if (reset) begin
      key   <= '0;
      mode  <= BS_EXACT;
      lo    <= '0;
      hi    <= '0;
      probe <= '0;
      hit   <= 1'b0;
      cnt   <= '0;
      found <= 1'b0;
      loc   <= '0;
    end else if (load) begin
      key   <= key_in;
      mode  <= decode_mode(mode_in);
      lo    <= '0;
      hi    <= DEPTH;
      hit   <= 1'b0;
      found <= 1'b0;
      loc   <= '0;
    end else if (issue) begin
      probe <= mid;
      cnt   <= CNT_INIT;
    end else if (in_wait) begin
      if (!last) begin
        cnt <= cnt - 1'b1;
      end else begin
        lo  <= lo_n;
        hi  <= hi_n;
        hit <= hit_n;
        if (converge) begin
          found <= res_found;
          loc   <= res_found ? lo_n[ADDR_W-1:0] : '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bsearch_gen.sv
`default_nettype none
// ============================================================================
// Module : bsearch_gen
// Brief  : Binary-search engine over an ascending-sorted external RAM with
//          exact / lower-bound / upper-bound modes and configurable read
//          latency. Holds the control FSM; arithmetic lives in the datapath.
// Rev    : 1.0  initial release
// ============================================================================
module bsearch_gen
  import bsearch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  bsearch_gen_if.slave  bus
);

  bs_state_e state, state_n;
  logic      load, issue, in_wait, last, converge, found_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic and control strobes.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    issue   = 1'b0;
    in_wait = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        in_wait = 1'b1;
        if (last) state_n = converge ? DONE : ISSUE;
      end
      DONE: begin
        if (!bus.start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.mem_rd_en = (state == ISSUE);
  assign bus.busy      = (state == ISSUE) || (state == WAIT);
  assign bus.done      = (state == DONE);
  assign bus.found     = bus.done & found_r;
  assign bus.notfound  = bus.done & ~found_r;

  bsearch_gen_datapath #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .issue    (issue),
    .in_wait  (in_wait),
    .key_in   (bus.A),
    .mode_in  (bus.mode),
    .rdata    (bus.mem_rdata),
    .addr     (bus.mem_addr),
    .last     (last),
    .converge (converge),
    .found    (found_r),
    .loc      (bus.loc)
  );

endmodule
`default_nettype wire
